mel_bank_serializer: RTL and testbench
======================================

// Module: mel_bank_serializer
// PURPOSE
//  Downstream end of the mel filter bank output interface. Accepts one frame of NUM_BANKS
//  parallel log-energies (dB) per s_valid/s_ready handshake, and re-emits it as a serial
//  word stream under m_valid/m_ready for the MFCC/DCT stage. Bank 0 goes first, with index and last tags.
// PARAMETERS
//  NUM_BANKS  40  number of mel banks per frame (2..63)
//  WIDTH      16  bits per bank energy word
// PORTS
//  clk      in   1                 single clock, all logic on posedge
//  reset    in   1                 asynchronous, active-low (0 = reset asserted)
//  in       in   WIDTH x NUM_BANKS frame of bank energies, in[0] = lowest bank
//  s_valid  in   1                 frame on `in` valid
//  s_ready  out  1                 block can capture a frame
//  out      out  WIDTH             current serial word
//  m_index  out  6                 bank index of `out` (NUM_BANKS for energy word, see CONFIGURATION)
//  m_last   out  1                 `out` is final word of frame
//  m_valid  out  1                 `out`/m_index/m_last valid
//  m_ready  in   1                 downstream accepts word
// BEHAVIOUR
//  - Reset values: state=IDLE, idx=0, frame buffer=0, s_ready=0, m_valid=0, m_last=0,
//    m_index=0, out=0. Reset mid-frame discards the frame; no partial words after release.
//  - FSM IDLE:
//    - s_ready=1 and m_valid=0.
//    - On s_valid&s_ready, register all of `in` into the frame buffer, set idx=0, go to STREAM.
//  - FSM STREAM:
//    - s_ready=0; `in` is ignored, so upstream holds the frame.
//    - m_valid=1, out=buf[idx], m_index=idx, m_last=(idx==LAST).
//    - LAST=NUM_BANKS-1, or NUM_BANKS when MEL_SER_ENERGY_EN is defined.
//  - Beat transfer on m_valid&m_ready:
//    - idx<LAST: idx+=1.
//    - idx==LAST: idx=0 and return to IDLE.
//  - m_ready low: out/m_index/m_last/m_valid hold stable until accepted. No word is dropped
//    or repeated.
//  - Latency: capture in cycle N gives word 0 valid in cycle N+1.
//    - m_ready held 1: LAST+1 consecutive beats.
//    - s_ready returns the cycle after the last beat, so there is one idle cycle between frames.
//  - s_valid while in STREAM: not accepted and no effect.
//  - s_valid&s_ready on the same edge as reset release: ignored.
//  - out is driven from registers through the idx mux only. There is no combinational path
//    from `in` to out.
// CONFIGURATION
//  MEL_SER_ENERGY_EN defined:
//    - During capture, accumulate sum of all NUM_BANKS words, unsigned, 22-bit (no overflow
//      for 40x16b).
//    - One extra word is appended after bank NUM_BANKS-1: out=sum[21:6] (sum/64, truncated),
//      m_index=NUM_BANKS, m_last=1. Frame is NUM_BANKS+1 beats.
//  MEL_SER_ENERGY_EN undefined:
//    - No accumulator. Frame is exactly NUM_BANKS beats; m_last on bank NUM_BANKS-1.
// TESTING
//  1 Reset low 3 cycles, then high -> during reset s_ready=0, m_valid=0. First cycle after
//    release: s_ready=1, m_valid=0.
//  2 in[i]=100*i+1, s_valid 1 cycle, m_ready=1 -> 40 beats next cycles: out=1,101,..,3901,
//    m_index=0..39, m_last only on 3901, s_ready=1 the cycle after.
//  3 Same frame, m_ready toggles 1,0,0,1 repeating -> identical 40-word sequence. Outputs
//    stable while m_ready=0. No drop or duplicate.
//  4 Second frame (in[i]=16'hFFFF-i) presented with s_valid high during streaming ->
//    not captured until IDLE. Then streamed intact after frame 1's last beat.
//  5 Reset pulled low at beat 17 of a frame -> m_valid=0 immediately. After release,
//    s_ready=1 and new frame starts at m_index=0.
//  6 MEL_SER_ENERGY_EN, all in=16'd6400 -> 41st beat out=16'd4000, m_index=40, m_last=1.
//    Beat 40 has m_last=0.

Source files
------------

// File: rtl/mel_bank_serializer.sv
// rtl/mel_bank_serializer.sv - mel bank frame to serial word stream; optional MEL_SER_ENERGY_EN appends a frame-energy word
module mel_bank_serializer #(
  parameter int NUM_BANKS = 40,
  parameter int WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_BANKS-1:0][WIDTH-1:0] in,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [WIDTH-1:0]                out,
  output logic [5:0]                      m_index,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready
);

`ifdef MEL_SER_ENERGY_EN
  localparam logic [5:0] LAST = 6'(NUM_BANKS);
`else
  localparam logic [5:0] LAST = 6'(NUM_BANKS - 1);
`endif

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [5:0]                      r_idx;
  logic [5:0]                      w_next_idx;
  logic                            r_armed;
  logic [NUM_BANKS-1:0][WIDTH-1:0] r_buf;
  logic                            w_capture;
  logic [WIDTH-1:0]                w_word;

  // r_armed keeps s_ready low until one full clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= 6'd0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready   = r_armed;
        w_capture = r_armed && s_valid;
        if (w_capture) begin
          w_next_state = ST_STREAM;
          w_next_idx   = 6'd0;
        end
      end
      ST_STREAM: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (r_idx == LAST) begin
            w_next_state = ST_IDLE;
            w_next_idx   = 6'd0;
          end else begin
            w_next_idx = r_idx + 6'd1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf <= '0;
    end else if (w_capture) begin
      r_buf <= in;
    end
  end

`ifdef MEL_SER_ENERGY_EN
  logic [21:0]      w_sum;
  logic [WIDTH-1:0] r_energy;

  always_comb begin
    w_sum = 22'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_sum = w_sum + 22'(in[i]);
    end
  end

  // Only the scaled energy (sum/64) is ever emitted, so only that is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_energy <= '0;
    end else if (w_capture) begin
      r_energy <= WIDTH'(w_sum >> 6);
    end
  end
`endif

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (r_idx == 6'(i)) begin
        w_word = r_buf[i];
      end
    end
`ifdef MEL_SER_ENERGY_EN
    if (r_idx == 6'(NUM_BANKS)) begin
      w_word = r_energy;
    end
`endif
  end

  assign out     = w_word;
  assign m_index = r_idx;
  assign m_last  = m_valid && (r_idx == LAST);

endmodule

// File: tb/tb_mel_bank_serializer.sv
// tb/tb_mel_bank_serializer.sv - randomized and directed bench for mel_bank_serializer with a queue-based frame model
module tb_mel_bank_serializer;

  localparam int NB = 40;
  localparam int W  = 16;
`ifdef MEL_SER_ENERGY_EN
  localparam int BEATS = NB + 1;
`else
  localparam int BEATS = NB;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NB-1:0][W-1:0]     in_bus = '0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [W-1:0]             out;
  logic [5:0]               m_index;
  logic                     m_last;
  logic                     m_valid;
  logic                     m_ready = 1'b0;

  mel_bank_serializer #(.NUM_BANKS(NB), .WIDTH(W)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .in      (in_bus),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .out     (out),
    .m_index (m_index),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    int           idx;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  bit           armed = 1'b0;
  int           total = 0;
  int           passed = 0;
  logic [W-1:0] log_word[$];
  int           log_idx[$];
  logic         log_last[$];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Model: a captured frame becomes a list of expected beats, consumed one per accepted word.
  task automatic push_frame(input logic [NB-1:0][W-1:0] f);
    longint sum = 0;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back('{word: f[i], idx: i, last: (i == BEATS - 1)});
      sum += f[i];
    end
`ifdef MEL_SER_ENERGY_EN
    exp_q.push_back('{word: W'(sum / 64), idx: NB, last: 1'b1});
`endif
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      armed = 1'b0;
    end else begin
      if (armed && exp_q.size() == 0 && s_valid) push_frame(in_bus);
      else if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      armed = 1'b0;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_out", out, 0);
      check("rst_m_index", m_index, 0);
      check("rst_m_last", m_last, 0);
    end else begin
      check("s_ready", s_ready, (armed && exp_q.size() == 0));
      check("m_valid", m_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out", out, exp_q[0].word);
        check("m_index", m_index, exp_q[0].idx);
        check("m_last", m_last, exp_q[0].last);
      end
      if (m_valid && m_ready) begin
        log_word.push_back(out);
        log_idx.push_back(int'(m_index));
        log_last.push_back(m_last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_word.delete();
    log_idx.delete();
    log_last.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c = 0;
    while (log_word.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (log_word.size() < n) check({name, "_timeout"}, log_word.size(), n);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NB; i++) in_bus[i] = W'(100 * i + 1);
  endtask

  initial begin
    int bad;
    int lasts;
    int c;
    logic [3:0] pat;

    // Reset held 3 cycles; s_valid high across the release edge must be ignored.
    rst_n = 1'b0;
    repeat (3) step();
    fill_ramp();
    s_valid = 1'b1;
    rst_n = 1'b1;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1);
    check("rel_m_valid", m_valid, 0);
    step();

    // Ramp frame, m_ready always high.
    clear_log();
    m_ready = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    wait_log(BEATS, 200, "t2");
    @(negedge clk);
    check("t2_s_ready_after", s_ready, 1);
    check("t2_first", log_word[0], 1);
    check("t2_w39", log_word[NB-1], 3901);
    check("t2_i39", log_idx[NB-1], 39);
    lasts = 0;
    foreach (log_last[i]) if (log_last[i]) lasts++;
    check("t2_last_count", lasts, 1);
    check("t2_last_pos", log_last[BEATS-1], 1);
    step();

    // Same frame with m_ready pattern 1,0,0,1.
    clear_log();
    pat = 4'b1001;
    s_valid = 1'b1;
    c = 0;
    while ((log_word.size() < BEATS || exp_q.size() != 0) && c < 400) begin
      m_ready = pat[c % 4];
      step();
      s_valid = 1'b0;
      c++;
    end
    check("t3_len", log_word.size(), BEATS);
    bad = 0;
    for (int i = 0; i < NB && i < log_word.size(); i++) begin
      if (log_word[i] != W'(100 * i + 1) || log_idx[i] != i) bad++;
    end
    check("t3_seq_bad", bad, 0);
    m_ready = 1'b1;
    step();

    // Second frame held on the input while the first streams.
    clear_log();
    s_valid = 1'b1;
    step();
    for (int i = 0; i < NB; i++) in_bus[i] = W'(16'hFFFF - i);
    wait_log(BEATS, 200, "t4a");
    step();
    s_valid = 1'b0;
    wait_log(2 * BEATS, 200, "t4b");
    check("t4_f1_first", log_word[0], 1);
    check("t4_f2_first", log_word[BEATS], 16'hFFFF);
    check("t4_f2_idx0", log_idx[BEATS], 0);
    check("t4_f2_w39", log_word[BEATS+NB-1], 16'hFFFF - 39);
    step();

    // Reset at beat 17.
    clear_log();
    fill_ramp();
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    wait_log(17, 100, "t5");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_m_valid_in_reset", m_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_log();
    for (int i = 0; i < NB; i++) in_bus[i] = W'($urandom);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    wait_log(1, 20, "t5b");
    check("t5_restart_idx", log_idx[0], 0);
    wait_log(BEATS, 200, "t5c");
    step();

`ifdef MEL_SER_ENERGY_EN
    clear_log();
    for (int i = 0; i < NB; i++) in_bus[i] = 16'd6400;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    wait_log(BEATS, 200, "t6");
    check("t6_energy", log_word[NB], 4000);
    check("t6_energy_idx", log_idx[NB], 40);
    check("t6_energy_last", log_last[NB], 1);
    check("t6_b39_last", log_last[NB-1], 0);
    step();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      s_valid = ($urandom_range(0, 2) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NB; i++) in_bus[i] = W'($urandom);
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (BEATS + 4) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
